// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: shared types and bit timing for the UART transmitter.
package uart_tx_ctrl_pkg;
    localparam int BIT_TIMING = 8;
    typedef logic bit_t;
    typedef logic [7:0] data_t;
    typedef logic [7:0] uartCounterDataType;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_tx_ctrl_timer.sv
// uart_timer: free-running bit timer, cleared by reset_timer, flags terminal count.
module uart_timer
    import uart_tx_ctrl_pkg::*;
#(
    parameter int bit_timing = BIT_TIMING
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_timer,
    output logic next_bit
);
    uartCounterDataType count;
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else        count <= reset_timer ? '0 : count + 1'b1;
    assign next_bit = count == uartCounterDataType'(bit_timing);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 / 8E1 UART transmit controller driving a registered serial line.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int bit_timing = BIT_TIMING
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       parity_en,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);
    state_t     state, state_n;
    data_t      data, data_n;
    bit_t       par_en, par_en_n;
    logic [2:0] idx, idx_n;
    bit_t       out_n, busy_n, done_n, reset_timer, rst_tmr_n, next_bit, adv, accept;

    uart_timer #(.bit_timing(bit_timing)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .reset_timer(reset_timer),
        .next_bit   (next_bit)
    );

    // next_bit is only trusted once the timer has actually been cleared
    always_comb begin
        accept   = state == IDLE && tx_start;
        adv      = next_bit && !reset_timer;
        state_n  = state;
        data_n   = data;
        par_en_n = par_en;
        idx_n    = idx;
        done_n   = 1'b0;
        if (accept) begin
            state_n  = START;
            data_n   = tx_data;
            par_en_n = parity_en;
            idx_n    = '0;
        end else if (adv) begin
            case (state)
                START:   state_n = DATA;
                DATA: begin
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = par_en ? PARITY : STOP;
                end
                PARITY:  state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        busy_n    = state_n != IDLE;
        rst_tmr_n = accept || adv || state_n == IDLE;
        out_n     = state_n == START  ? 1'b0 :
                    state_n == DATA   ? data_n[idx_n] :
                    state_n == PARITY ? ^data_n : 1'b1;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= IDLE;
            data        <= '0;
            par_en      <= 1'b0;
            idx         <= '0;
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            reset_timer <= 1'b1;
        end else begin
            state       <= state_n;
            data        <= data_n;
            par_en      <= par_en_n;
            idx         <= idx_n;
            tx_out      <= out_n;
            tx_busy     <= busy_n;
            tx_done     <= done_n;
            reset_timer <= rst_tmr_n;
        end
endmodule
